// File: rtl/ser2par_align_if.sv
// Receive-side serial input and aligned-symbol output bundle.
// master drives data_in/RXPOL; slave (the aligner) drives the rest.
interface ser2par_align_if;
  logic       data_in;
  logic       RXPOL;
  logic [9:0] data_out;
  logic       data_valid;
  logic       is_comma;
  logic       locked;
  logic       realign;

  modport master (
    output data_in,
    output RXPOL,
    input  data_out,
    input  data_valid,
    input  is_comma,
    input  locked,
    input  realign
  );

  modport slave (
    input  data_in,
    input  RXPOL,
    output data_out,
    output data_valid,
    output is_comma,
    output locked,
    output realign
  );
endinterface

// File: rtl/ser2par_align.sv
// Comma-aligned 1:10 deserializer for the 8b/10b receive path.
// Ports: CRC_CKL bit clock, RESET async high, rx bus (serial in, symbols out).
module ser2par_align #(
  parameter logic [9:0] COMMA_P  = 10'h17C,
  parameter logic [9:0] COMMA_N  = 10'h283,
  parameter int         LOCK_CNT = 3,
  parameter int         LOSS_CNT = 4
) (
  input  logic           CRC_CKL,
  input  logic           RESET,
  ser2par_align_if.slave rx
);

  localparam logic [2:0] LOCK_N = 3'(LOCK_CNT);
  localparam logic [2:0] LOSS_N = 3'(LOSS_CNT);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] sr_q, sr_d;
  logic [3:0] ph_q, ph_d;
  logic [2:0] good_q, good_d;
  logic [2:0] bad_q, bad_d;
  logic [9:0] dout_q, dout_d;
  logic       valid_q, valid_d;
  logic       comma_q, comma_d;
  logic       lock_q, lock_d;
  logic       realign_q, realign_d;

  logic       d;
  logic       hit;
  logic       ph_zero;
  logic [3:0] ph_inc;
  logic [2:0] good_inc;
  logic [2:0] bad_inc;

  assign d        = rx.data_in ^ rx.RXPOL;
  assign hit      = (sr_q == COMMA_P) ||
                    (sr_q == COMMA_N);
  assign ph_zero  = (ph_q == 4'd0);
  assign ph_inc   = (ph_q == 4'd9) ? 4'd0
                                   : ph_q + 4'd1;
  assign good_inc = good_q + 3'd1;
  assign bad_inc  = bad_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    sr_d      = {d, sr_q[9:1]};
    ph_d      = ph_inc;
    good_d    = good_q;
    bad_d     = bad_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    comma_d   = 1'b0;
    lock_d    = lock_q;
    realign_d = 1'b0;

    unique case (state_q)
      HUNT: begin
        ph_d  = 4'd0;
        bad_d = 3'd0;
        if (hit) begin
          // sr holds a whole symbol now, so
          // the next one completes 10 edges on.
          ph_d      = 4'd1;
          good_d    = 3'd1;
          realign_d = 1'b1;
          if (good_inc == 3'd1 &&
              LOCK_N == 3'd1) begin
            state_d = LOCKED;
            lock_d  = 1'b1;
            dout_d  = sr_q;
            valid_d = 1'b1;
            comma_d = 1'b1;
          end else begin
            state_d = VERIFY;
          end
        end
      end

      VERIFY: begin
        if (hit && ph_zero) begin
          good_d = good_inc;
          if (good_inc == LOCK_N) begin
            // The locking comma is also the
            // first symbol handed downstream.
            state_d = LOCKED;
            lock_d  = 1'b1;
            dout_d  = sr_q;
            valid_d = 1'b1;
            comma_d = 1'b1;
          end
        end else if (hit) begin
          ph_d      = 4'd1;
          good_d    = 3'd1;
          realign_d = 1'b1;
        end
      end

      LOCKED: begin
        if (ph_zero) begin
          dout_d  = sr_q;
          valid_d = 1'b1;
          comma_d = hit;
          if (hit) begin
            bad_d = 3'd0;
          end
        end else if (hit) begin
          // Off-phase comma, including one that
          // straddles two data symbols.
          bad_d = bad_inc;
          if (bad_inc == LOSS_N) begin
            state_d = HUNT;
            lock_d  = 1'b0;
            good_d  = 3'd0;
            bad_d   = 3'd0;
          end
        end
      end

      default: begin
        state_d = HUNT;
        lock_d  = 1'b0;
        good_d  = 3'd0;
        bad_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge CRC_CKL or posedge RESET) begin
    if (RESET) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      ph_q      <= '0;
      good_q    <= '0;
      bad_q     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      comma_q   <= 1'b0;
      lock_q    <= 1'b0;
      realign_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      ph_q      <= ph_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      comma_q   <= comma_d;
      lock_q    <= lock_d;
      realign_q <= realign_d;
    end
  end

  assign rx.data_out   = dout_q;
  assign rx.data_valid = valid_q;
  assign rx.is_comma   = comma_q;
  assign rx.locked     = lock_q;
  assign rx.realign    = realign_q;

endmodule

// File: tb/tb_ser2par_align.sv
// Directed bench for ser2par_align with an expected-symbol queue.
// Covers reset, acquisition, polarity, slip, hysteresis, re-anchor.
`timescale 1ns/1ps
module tb_ser2par_align;

  localparam logic [9:0] P = 10'h17C;
  localparam logic [9:0] N = 10'h283;

  logic clk = 1'b0;
  logic rst;

  ser2par_align_if bus();

  ser2par_align dut (
    .CRC_CKL (clk),
    .RESET   (rst),
    .rx      (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] data;
    logic       comma;
  } exp_t;

  exp_t q[$];

  int   nchk  = 0;
  int   nerr  = 0;
  int   cyc   = 0;
  int   rcnt  = 0;
  int   rcyc  = -1;
  int   lrise = -1;
  int   lfall = -1;
  int   lfcnt = 0;
  int   vcyc  = 0;
  bit   vrun  = 0;
  logic lprev = 1'b0;
  int   last_end;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [9:0] dv,
                          input logic cv);
    exp_t e;
    e.data  = dv;
    e.comma = cv;
    q.push_back(e);
  endtask

  task automatic step(input logic b);
    exp_t e;
    @(negedge clk);
    bus.data_in = b;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.realign === 1'b1) begin
      rcnt++;
      rcyc = cyc;
    end
    if (bus.locked === 1'b1 && lprev !== 1'b1)
      lrise = cyc;
    if (bus.locked !== 1'b1 && lprev === 1'b1) begin
      lfall = cyc;
      lfcnt++;
    end
    lprev = bus.locked;
    if (bus.locked !== 1'b1) vrun = 0;
    if (bus.data_valid === 1'b1) begin
      chk("valid_expected",
          32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("data_out", 32'(bus.data_out),
            32'(e.data));
        chk("is_comma", 32'(bus.is_comma),
            32'(e.comma));
      end
      if (vrun) chk("valid_period",
                    cyc - vcyc, 32'd10);
      vrun = 1;
      vcyc = cyc;
    end
  endtask

  task automatic send_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) step(s[i]);
    last_end = cyc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.data_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lprev = 1'b0;
    vrun = 0;
  endtask

  initial begin
    logic [6:0] r7;
    logic [9:0] nraw;
    logic [9:0] mix;
    logic [9:0] sl;
    logic [9:0] padw;
    int c1, c2, c4, c5, c7, rc0, lf0;

    rst = 1'b1;
    bus.data_in = 1'b0;
    bus.RXPOL = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_valid", 32'(bus.data_valid), 32'd0);
    chk("rst_comma", 32'(bus.is_comma), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_realign", 32'(bus.realign), 32'd0);
    rst = 1'b0;

    // Acquisition
    r7 = 7'($urandom);
    if (r7 == 7'b1011111) r7 = r7 ^ 7'h01;
    for (int i = 0; i < 7; i++) step(r7[i]);
    send_sym(P);
    c1 = last_end;
    send_sym(P);
    push_exp(P, 1'b1);
    send_sym(P);
    push_exp(10'h0AA, 1'b0);
    send_sym(10'h0AA);
    push_exp(10'h155, 1'b0);
    send_sym(10'h155);
    step(1'b0);
    chk("acq_realign_cnt", rcnt, 32'd1);
    chk("acq_realign_cyc", rcyc, c1 + 1);
    chk("acq_lock_cyc", lrise, c1 + 21);
    chk("acq_locked", 32'(bus.locked), 32'd1);

    // Reset while locked
    rst = 1'b1;
    #1;
    chk("mid_rst_data_out", 32'(bus.data_out), 32'd0);
    chk("mid_rst_valid", 32'(bus.data_valid), 32'd0);
    chk("mid_rst_comma", 32'(bus.is_comma), 32'd0);
    chk("mid_rst_locked", 32'(bus.locked), 32'd0);
    chk("mid_rst_realign", 32'(bus.realign), 32'd0);
    rst = 1'b0;
    lprev = 1'b0;
    vrun = 0;
    send_sym(10'h0AA);
    send_sym(10'h155);
    chk("post_rst_locked", 32'(bus.locked), 32'd0);
    chk("post_rst_realign_cnt", rcnt, 32'd1);

    // Inverted stream with RXPOL=1
    bus.RXPOL = 1'b1;
    rc0 = rcnt;
    for (int i = 0; i < 7; i++) step(~r7[i]);
    send_sym(~P);
    c1 = last_end;
    send_sym(~P);
    push_exp(P, 1'b1);
    send_sym(~P);
    push_exp(10'h0AA, 1'b0);
    send_sym(~10'h0AA);
    push_exp(10'h155, 1'b0);
    send_sym(~10'h155);
    chk("pol_realign_cnt", rcnt, rc0 + 1);
    chk("pol_realign_cyc", rcyc, c1 + 1);
    chk("pol_lock_cyc", lrise, c1 + 21);

    // RXPOL toggled halfway through a symbol
    nraw = N;
    mix = {nraw[9:5], ~nraw[4:0]};
    push_exp(mix, 1'b0);
    for (int i = 0; i < 5; i++) step(nraw[i]);
    bus.RXPOL = 1'b0;
    for (int i = 5; i < 10; i++) step(nraw[i]);
    push_exp(N, 1'b1);
    send_sym(N);
    push_exp(P, 1'b1);
    send_sym(P);
    chk("tog_locked", 32'(bus.locked), 32'd1);
    chk("tog_no_fall", lfcnt, 32'd0);

    // Slip by one bit
    rc0 = rcnt;
    sl = {P[8:0], P[9]};
    step(1'b0);
    for (int k = 0; k < 4; k++) begin
      push_exp(sl, 1'b0);
      send_sym(P);
    end
    c4 = last_end;
    chk("slip_locked_c4", 32'(bus.locked), 32'd1);
    send_sym(P);
    c5 = last_end;
    chk("slip_fall_cyc", lfall, c4 + 1);
    chk("slip_fall_cnt", lfcnt, 32'd1);
    send_sym(P);
    push_exp(P, 1'b1);
    send_sym(P);
    c7 = last_end;
    step(1'b0);
    chk("slip_realign_cyc", rcyc, c5 + 1);
    chk("slip_realign_cnt", rcnt, rc0 + 1);
    chk("slip_relock_cyc", lrise, c7 + 1);

    // Hysteresis: 3 off-phase commas, then aligned
    lf0 = lfcnt;
    rc0 = rcnt;
    padw = {9'd0, P[9]};
    for (int r = 0; r < 2; r++) begin
      if (r != 0) step(1'b0);
      for (int k = 0; k < 3; k++) begin
        push_exp(sl, 1'b0);
        send_sym(P);
      end
      chk("hyst_locked_3bad", 32'(bus.locked), 32'd1);
      push_exp(padw, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b0);
      push_exp(P, 1'b1);
      send_sym(P);
    end
    step(1'b0);
    chk("hyst_locked", 32'(bus.locked), 32'd1);
    chk("hyst_no_fall", lfcnt, lf0);
    chk("hyst_no_realign", rcnt, rc0);

    // Re-anchor during VERIFY
    do_reset();
    rc0 = rcnt;
    send_sym(P);
    c1 = last_end;
    for (int i = 0; i < 3; i++) step(1'b0);
    chk("va_realign1_cyc", rcyc, c1 + 1);
    send_sym(P);
    c2 = last_end;
    send_sym(P);
    chk("va_realign_cnt", rcnt, rc0 + 2);
    chk("va_realign2_cyc", rcyc, c2 + 1);
    push_exp(P, 1'b1);
    send_sym(P);
    c4 = last_end;
    chk("va_unlocked_c4", 32'(bus.locked), 32'd0);
    push_exp(10'h0AA, 1'b0);
    send_sym(10'h0AA);
    step(1'b0);
    chk("va_lock_cyc", lrise, c4 + 1);
    chk("va_locked", 32'(bus.locked), 32'd1);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
